// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, default round count, round-constant
// lookup and the S-box, used by the round controller and the datapath modules.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam int unsigned NR_DEFAULT = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, which maps 0 to 0) followed by
  // the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake/data bundle of the AES round controller.
//   in_valid/in_ready/in_data/key : plaintext+key input handshake
//   out_valid/out_ready/out_data  : ciphertext output handshake
//   busy                          : block in flight (ROUND or DONE)
// slave = controller side, master = producer/consumer side.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, key, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: current round key -> next round key.
//   rkey      : current round key (w0 in bits [127:96])
//   rcon      : round constant for this step
//   next_rkey : next round key
module aes_key_step (
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon,
  output logic [127:0] next_rkey
);
  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  always_comb begin
    w0   = rkey[127:96];
    w1   = rkey[95:64];
    w2   = rkey[63:32];
    w3   = rkey[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {aes_pkg::sbox(rot[31:24]), aes_pkg::sbox(rot[23:16]),
            aes_pkg::sbox(rot[15:8]),  aes_pkg::sbox(rot[7:0])} ^ {rcon, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_rkey = {n0, n1, n2, n3};
  end
endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns: each 32-bit column multiplied by the fixed {02,03,01,01} matrix.
//   din  : 128-bit state in
//   dout : 128-bit state out
module aes_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = din[127 - 32*c      -: 8];
      a1 = din[127 - 32*c - 8  -: 8];
      a2 = din[127 - 32*c - 16 -: 8];
      a3 = din[127 - 32*c - 24 -: 8];
      dout[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      dout[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      dout[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      dout[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end
endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows over the column-major layout: byte index 4*c+r sits at bits
// [127-8*(4*c+r) -: 8]; row r is rotated left by r columns.
//   din  : 128-bit state in
//   dout : 128-bit state out
module aes_shift_rows (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end
endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: applies the S-box to each of the 16 state bytes.
//   din  : 128-bit state in
//   dout : 128-bit state out
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of aes_round_ctrl_if (input/output handshakes, busy)
// IDLE accepts a block (initial AddRoundKey), ROUND runs rounds 1..NR,
// DONE presents the ciphertext until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_ctrl_if.slave   bus
);
  localparam logic [3:0] LAST = 4'(NR);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [127:0] sb, sr, mc, next_rkey, round_out;

  aes_sub_bytes   u_sub   (.din(state_q), .dout(sb));
  aes_shift_rows  u_shift (.din(sb),      .dout(sr));
  aes_mix_columns u_mix   (.din(sr),      .dout(mc));
  aes_key_step    u_key   (.rkey(rkey_q), .rcon(rcon(round_q)), .next_rkey(next_rkey));

  // Final round skips MixColumns.
  assign round_out = ((round_q == LAST) ? sr : mc) ^ next_rkey;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = bus.in_data ^ bus.key;
          rkey_d  = bus.key;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        rkey_d  = next_rkey;
        if (round_q == LAST) fsm_d = DONE;
        else                 round_d = round_q + 4'd1;
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Outputs are registered from the next state, so out_valid rises on the
    // edge completing round NR (the NR+1-th edge counting the handshake edge)
    // and in_ready only returns the cycle after the output handshake.
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      round_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_valid_q ? state_q : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] JUNK  = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

  aes_round_ctrl_if bus();

  aes_round_ctrl #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one block in and waits for out_valid; no checking here.
  // lat counts clock edges from the handshake edge (inclusive) to out_valid.
  task automatic do_block(input logic [127:0] pt, input logic [127:0] k,
                          output int lat, output logic [127:0] dout,
                          output logic mid_busy, output logic mid_rdy,
                          output bit timeout);
    int w;
    timeout  = 1'b0;
    lat      = 0;
    mid_busy = 1'b0;
    mid_rdy  = 1'b1;
    dout     = '0;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      timeout = 1'b1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    bus.key      = k;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = JUNK;
    bus.key      = ~JUNK;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (lat == 5) begin
        mid_busy = bus.busy;
        mid_rdy  = bus.in_ready;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) timeout = 1'b1;
    dout = bus.out_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b busy=%b out_data=%h, expected all zero",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_held: in_ready=%b out_valid=%b busy=%b out_data=%h, expected all zero",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_no_edge: in_ready=%b expected 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_edge: in_ready=%b busy=%b out_valid=%b expected 1/0/0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_fips_vector(input logic [127:0] pt, input logic [127:0] k,
                                  input logic [127:0] ct, input string name);
    int lat;
    logic [127:0] dout;
    logic mb, mr;
    bit to;
    do_block(pt, k, lat, dout, mb, mr, to);
    vectors++;
    if (to || lat != 11) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d edges (timeout=%0b), expected 11", name, lat, to);
    end
    vectors++;
    if (dout !== ct) begin
      miscompares++;
      $display("FAIL %s_data: got %h expected %h", name, dout, ct);
    end
    vectors++;
    if (mb !== 1'b1 || mr !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_mid_round: busy=%b in_ready=%b expected 1/0", name, mb, mr);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL %s_after_out_hs: out_valid=%b out_data=%h expected 0/0", name, bus.out_valid, bus.out_data);
    end
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_after: in_ready=%b busy=%b expected 1/0", name, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [127:0] dout;
    logic mb, mr;
    bit to;
    do_block(PT_A, KEY_A, lat, dout, mb, mr, to);
    vectors++;
    if (to || dout !== CT_A) begin
      miscompares++;
      $display("FAIL bp_data: got %h (timeout=%0b) expected %h", dout, to, CT_A);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== CT_A || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_data=%h in_ready=%b busy=%b expected 1/%h/0/1",
                 i, bus.out_valid, bus.out_data, bus.in_ready, bus.busy, CT_A);
      end
      if (i == 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = PT_B;
        bus.key      = KEY_B;
      end
      if (i == 6) bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL bp_release: out_valid=%b out_data=%h expected 0/0", bus.out_valid, bus.out_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_queue: out_valid=%b busy=%b in_ready=%b expected 0/0/1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pts  [3];
    logic [127:0] keys [3];
    logic [127:0] cts  [3];
    int in_idx, out_idx, last_in, last_out;
    bit accepted;
    pts[0] = PT_A; keys[0] = KEY_A; cts[0] = CT_A;
    pts[1] = PT_B; keys[1] = KEY_B; cts[1] = CT_B;
    pts[2] = PT_A; keys[2] = KEY_A; cts[2] = CT_A;
    in_idx = 0; out_idx = 0; last_in = -1; last_out = -1; accepted = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = pts[0];
    bus.key       = keys[0];
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bus.out_valid) begin
        vectors++;
        if (bus.out_data !== cts[out_idx]) begin
          miscompares++;
          $display("FAIL b2b_data_%0d: got %h expected %h", out_idx, bus.out_data, cts[out_idx]);
        end
        if (last_out >= 0) begin
          vectors++;
          if (cyc - last_out != 12) begin
            miscompares++;
            $display("FAIL b2b_out_spacing_%0d: got %0d cycles expected 12", out_idx, cyc - last_out);
          end
        end
        last_out = cyc;
        out_idx++;
        if (in_idx < 3) begin
          bus.in_data = pts[in_idx];
          bus.key     = keys[in_idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end else if (bus.in_ready && in_idx < 3) begin
        if (last_in >= 0) begin
          vectors++;
          if (cyc - last_in != 12) begin
            miscompares++;
            $display("FAIL b2b_in_spacing_%0d: got %0d cycles expected 12", in_idx, cyc - last_in);
          end
        end
        last_in = cyc;
        in_idx++;
        accepted = 1'b1;
      end else if (accepted) begin
        // key and data change while the block is in ROUND
        bus.in_data = JUNK;
        bus.key     = ~JUNK;
        accepted    = 1'b0;
      end
      if (out_idx == 3) break;
      @(negedge clk);
    end
    vectors++;
    if (out_idx != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d outputs expected 3", out_idx);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end_idle: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_round;
    int lat;
    logic [127:0] dout;
    logic mb, mr;
    bit to;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = PT_A;
    bus.key      = KEY_A;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_immediate: out_valid=%b busy=%b in_ready=%b out_data=%h expected zeros",
               bus.out_valid, bus.busy, bus.in_ready, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_no_output_%0d: out_valid=%b expected 0", i, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle: in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy);
    end
    do_block(PT_B, KEY_B, lat, dout, mb, mr, to);
    vectors++;
    if (to || lat != 11 || dout !== CT_B) begin
      miscompares++;
      $display("FAIL rst_mid_recover: lat=%0d timeout=%0b data=%h expected 11/0/%h", lat, to, dout, CT_B);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.key      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips_vector(PT_A, KEY_A, CT_A, "fips_c1");
    test_fips_vector(PT_B, KEY_B, CT_B, "fips_b");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
